// File: rtl/trigger_pkg.sv
// trigger_pkg: shared state, mode and channel-limit definitions for trigger_gen
package trigger_pkg;
   typedef enum logic {ST_IDLE, ST_RUN} state_t;
   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;
   localparam int MAX_CH = 16;
endpackage

// File: rtl/trigger_chan.sv
// trigger_chan: one trigger channel with shadowed delay/width and a registered window compare
module trigger_chan #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic             run,
   input  logic             latch,
   input  logic             clear,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   output logic             tx
);
   logic [CNT_W-1:0] delay_s, width_s;
   logic [CNT_W:0]   window_end;
   logic             hit;
   // The window end carries an extra bit so delay + width never wraps.
   always_comb begin
      window_end = {1'b0, delay_s} + {1'b0, width_s};
      hit = run && cnt >= delay_s && {1'b0, cnt} < window_end;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         delay_s <= '0;
         width_s <= '0;
         tx <= 1'b0;
      end else begin
         if (latch) begin
            delay_s <= delay;
            width_s <= width;
         end
         tx <= clear ? 1'b0 : hit;
      end
   end
endmodule

// File: rtl/trigger_gen.sv
// trigger_gen: multi-channel trigger generator with a shared base counter and one-shot/periodic runs
module trigger_gen
   import trigger_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int NUM_CH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    mode,
   input  logic [CNT_W-1:0]        period,
   input  logic [NUM_CH*CNT_W-1:0] ch_delay,
   input  logic [NUM_CH*CNT_W-1:0] ch_width,
   output logic [NUM_CH-1:0]       tx,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   state_t           state;
   logic [CNT_W-1:0] cnt, period_s;
   logic             mode_s, run, wrap, stop_now, accept, latch;
   always_comb begin
      run = state == ST_RUN;
      wrap = cnt == period_s - CNT_W'(1);
      stop_now = run && stop;
      accept = !run && start && period != '0;
      // Periodic runs pick up new configuration only at a period boundary.
      latch = accept || (run && !stop && wrap && mode_s == MODE_PERIODIC);
   end
   assign busy = run;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt <= '0;
         period_s <= '0;
         mode_s <= MODE_PERIODIC;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= run && !stop && wrap;
         err <= !run && start && period == '0;
         if (stop_now) begin
            state <= ST_IDLE;
            cnt <= '0;
         end else if (run && wrap) begin
            cnt <= '0;
            if (mode_s == MODE_ONESHOT) state <= ST_IDLE;
            else period_s <= period;
         end else if (run) begin
            cnt <= cnt + CNT_W'(1);
         end else if (accept) begin
            state <= ST_RUN;
            cnt <= '0;
            mode_s <= mode;
            period_s <= period;
         end
      end
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      trigger_chan #(.CNT_W(CNT_W)) u_chan (
         .clk  (clk),
         .rst  (rst),
         .cnt  (cnt),
         .run  (run),
         .latch(latch),
         .clear(stop_now),
         .delay(ch_delay[i*CNT_W +: CNT_W]),
         .width(ch_width[i*CNT_W +: CNT_W]),
         .tx   (tx[i])
      );
   end
endmodule

// File: doc/trigger_gen.md
# trigger_gen

Parametrised multi-channel trigger generator. It uses one shared base counter per run and drives NUM_CH independent pulse outputs, each with its own programmable delay and width inside a programmable period. It runs in one-shot or periodic mode, with start/stop control and status outputs. It is the generalised successor of the single fixed-pulse trigger and sits between the control registers and external trigger pins.

## Interface
- CNT_W, 32, width of the base counter and of all timing fields
- NUM_CH, 4, number of trigger channels (1..16)
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  abort the run; sampled only in RUN
- mode  in  1  0 = periodic, 1 = one-shot; latched on start
- period  in  CNT_W  cycles per period; latched on start and at each wrap
- ch_delay  in  NUM_CH*CNT_W  per-channel delay; channel i occupies bits [i*CNT_W +: CNT_W]; latched with period
- ch_width  in  NUM_CH*CNT_W  per-channel pulse width, same packing; latched with period
- tx  out  NUM_CH  trigger outputs, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at every period wrap
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE and RUN.
- Reset values: state = IDLE, cnt = 0, tx = 0, busy = 0, done = 0, err = 0, shadow registers = 0.
- Control priority, highest first: rst, stop, wrap, start.
- **IDLE, start = 1, period != 0:** latch mode, period, delays and widths into the shadow registers; set cnt = 0; go to RUN.
- **IDLE, start = 1, period == 0:** pulse err; stay in IDLE.
- **RUN:**
  - If cnt != period_s − 1: cnt increments.
  - If cnt == period_s − 1 (wrap): pulse done and set cnt = 0.
    - One-shot: go to IDLE.
    - Periodic: relatch the shadow registers from the inputs, so new configuration takes effect only at period boundaries.
- **Stop in RUN:** go to IDLE, clear cnt and tx on the same edge, and pulse neither done nor err.
- **Start in RUN:** ignored; there is no retrigger.
- **Channel compare.**
  - Per channel, hit_i = RUN && cnt >= delay_i && cnt < delay_i + width_i.
  - The sum delay_i + width_i is computed at CNT_W+1 bits, so it never wraps.
  - Register the result: tx[i] <= hit_i.
- **Channel boundary cases:**
  - width_i == 0: the channel never fires.
  - delay_i >= period_s: the channel never fires.
  - A pulse extending past period_s − 1 is truncated at the wrap; it does not spill into the next period.
  - With period_s == 1, cnt stays 0. In periodic mode, any channel with delay 0 and width >= 1 is high continuously.
- **Output:** busy = (state == RUN), driven from the state register.

## Timing
- Let edge E0 be the edge that samples start. After E0, cnt = 0.
- For channel i, tx[i] rises after edge E0 + delay_i + 1 and stays high for min(width_i, period_s − delay_i) cycles.
- tx lags cnt by exactly one cycle.
- done is high in the cycle after the edge where cnt == period_s − 1 was sampled.
- In one-shot mode:
  - The final compare result, for cnt = period_s − 1, appears on tx in the first IDLE cycle.
  - tx is 0 from the second IDLE cycle onward.
  - busy falls on the same edge that raises done.
- Periodic mode has no dead cycle between periods: cnt goes period_s − 1 → 0.
- Reset mid-run: every output is at its reset value in the cycle after the rst edge.
- Back-to-back runs: a start in the cycle immediately after a one-shot returns to IDLE is accepted.

## Structure
- Package trigger_pkg holds:
  - the state enum (ST_IDLE, ST_RUN);
  - the mode constants MODE_PERIODIC = 0 and MODE_ONESHOT = 1;
  - the limit MAX_CH = 16.
- Sub-module trigger_chan, instantiated NUM_CH times, contains:
  - the delay and width shadow registers;
  - the (CNT_W+1)-bit window compare;
  - the tx flop.
  It takes cnt, run, latch and clear from the top level.
- The top level holds the FSM, cnt, period_s, mode_s and the done/err flops.

## Test plan
- **Legacy equivalent.** NUM_CH = 1, one-shot, period 100, delay 50, width 1, start at E0. Required: tx is high for exactly the one cycle after edge E0+51; busy falls and done pulses after edge E0+100.
- **Periodic, 4 channels.** period 10; delays 0/3/5/9; widths 2/1/5/3. Required over 3 periods:
  - ch0 is high 2 cycles each period;
  - ch2 is high 5 cycles, delay 5 through period end;
  - ch3 is truncated to 1 cycle, at delay 9;
  - done pulses every 10 cycles.
- **Degenerate configuration.** Start with period 0 → err pulses and busy stays 0. Width 0 and delay ≥ period → tx stays 0 for the whole run.
- **Stop.** Assert stop during a ch1 pulse → tx = 0, cnt = 0 and busy = 0 after that edge; no done pulse.
- **Relatch.** In periodic mode, change period 10 → 6 mid-period → the current period still completes at 10 cycles and the next period is 6 cycles.
- **Reset and retrigger.** Assert rst mid-run → all outputs 0 next cycle. A start during RUN is ignored: the done spacing is unchanged.
